spm_host_if: RTL and testbench
==============================

// Module: spm_host_if
// PURPOSE
//   Host-side driver for the spm serial-parallel multiplier; the counterpart that feeds it and drains it.
//   Accepts a parallel operand pair, presents x to spm in parallel, and streams y LSB-first on spm_y.
//   Collects the serial product from spm_p into a 2*WIDTH-bit parallel result.
//   Uses a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//   WIDTH  8  operand width; must equal the x width of the attached spm instance; product is 2*WIDTH
//   P_LAT  1  cycles from spm_y carrying bit k to spm_p carrying product bit k (range 0..3)
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst        in   1        asynchronous, active-low reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        block can accept an operand pair
//   in_x       in   WIDTH    parallel multiplicand
//   in_y       in   WIDTH    multiplier; serialised onto spm_y
//   spm_x      out  WIDTH    parallel operand to spm; held stable for the whole run
//   spm_y      out  1        serial multiplier bit to spm, LSB first
//   spm_clr    out  1        one-cycle clear pulse to the spm CSA chain before each run
//   spm_p      in   1        serial product bit from spm
//   out_valid  out  1        result valid; held until accepted
//   out_ready  in   1        consumer accepts result
//   out_p      out  2*WIDTH  parallel product
// BEHAVIOUR
//   Reset (rst low, async): state=IDLE; in_ready=0 while rst low, 1 in the first cycle after release;
//     spm_x=0, spm_y=0, spm_clr=0, out_valid=0, out_p=0, cnt=0.
//   FSM states: IDLE, CLR, RUN, DONE.
//   IDLE: in_ready=1. in_valid&in_ready -> latch in_x into spm_x and in_y into shift reg ys; goto CLR.
//   CLR: exactly one cycle with spm_clr=1, spm_y=0; cnt<=0; goto RUN.
//   RUN: lasts 2*WIDTH+P_LAT cycles, indexed by cnt=0..2*WIDTH+P_LAT-1.
//     For cnt<WIDTH, spm_y=ys[cnt].
//     For WIDTH<=cnt<2*WIDTH, spm_y=extension bit (see CONFIGURATION).
//     For cnt>=2*WIDTH, spm_y=0.
//     When cnt>=P_LAT: out_p <= {spm_p, out_p[2W-1:1]} (right shift, insert at MSB).
//       The last insert happens at cnt=2*WIDTH+P_LAT-1, so product bit 0 ends up in out_p[0].
//     At the last RUN cycle: goto DONE.
//   DONE: out_valid=1; out_p held stable; out_valid&out_ready -> out_valid<=0, goto IDLE.
//   Latency: 1 (CLR) + 2*WIDTH + P_LAT cycles from in handshake to out_valid rising (W=8, P_LAT=1: 18).
//   in_ready=0 in CLR/RUN/DONE; in_valid in those states is ignored and not queued.
//   No result-to-IDLE bypass: the next operand pair is accepted at the earliest one cycle after the out handshake.
//   out_p is modulo 2^(2*WIDTH); no overflow flag.
//   cnt width is clog2(2*WIDTH+P_LAT+1); cnt never wraps within a run.
//   Reset mid-run: asserting rst immediately aborts the run; the partial product is discarded.
//     No spm_clr is emitted on reset; the next run's CLR cycle clears spm.
//   spm_x changes only on the IDLE accept edge.
// CONFIGURATION
//   SPM_HOST_SIGNED_EN defined: upper-phase spm_y = in_y[WIDTH-1] (sign extension); two's-complement product.
//   SPM_HOST_SIGNED_EN undefined: upper-phase spm_y = 0; unsigned product.
//   FSM, timing and ports are identical in both builds.
// TESTING (WIDTH=8, P_LAT=1, bench models spm behaviourally)
//   x=8'd3, y=8'd5, out_ready=1 -> out_valid high 18 cycles after accept, out_p=16'h000F, in_ready=1 next cycle.
//   unsigned build: x=8'hFF, y=8'hFF -> out_p=16'hFE01.
//   signed build: x=8'hFF(-1), y=8'h02 -> out_p=16'hFFFE; x=8'h80, y=8'h80 -> out_p=16'h4000.
//   out_ready held 0 for 10 cycles in DONE -> out_valid and out_p stable; 2nd in_valid ignored; in_ready=0.
//   rst low at RUN cnt=5 -> all outputs 0 immediately; after release, x=2, y=7 -> out_p=16'h000E.
//   Back-to-back: 3 operand pairs with in_valid held 1 -> each accepted 1 cycle after the prior out handshake; spm_clr pulses once per run.

Source files
------------

// File: rtl/spm_host_if.sv
// Host-side driver for the spm serial-parallel multiplier: loads x in parallel, streams y LSB-first,
// gathers the serial product into a parallel result. Define SPM_HOST_SIGNED_EN for a two's-complement product.
module spm_host_if #(
  parameter int WIDTH = 8,
  parameter int P_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  output logic                 spm_clr,
  input  logic                 spm_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int RUNLEN = 2*WIDTH + P_LAT;
  localparam int CW     = $clog2(RUNLEN + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     ys_q;
  logic [WIDTH-1:0]     spm_x_q;
  logic                 in_ready_q;
  logic                 spm_y_q;
  logic                 spm_clr_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   out_p_q;

  logic [CW-1:0]        idx_d;
  logic                 spm_y_d;
  logic                 ext_bit;

`ifdef SPM_HOST_SIGNED_EN
  assign ext_bit = ys_q[WIDTH-1];
`else
  assign ext_bit = 1'b0;
`endif

  // spm_y is registered, so the bit for the *next* RUN index is selected one cycle early.
  always_comb begin
    idx_d   = (state_q == CLR) ? '0 : cnt_q + 1'b1;
    spm_y_d = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx_d == CW'(i)) spm_y_d = ys_q[i];
    end
    if (idx_d >= CW'(WIDTH) && idx_d < CW'(2*WIDTH)) spm_y_d = ext_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ys_q        <= '0;
      spm_x_q     <= '0;
      in_ready_q  <= 1'b0;
      spm_y_q     <= 1'b0;
      spm_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            spm_x_q    <= in_x;
            ys_q       <= in_y;
            spm_clr_q  <= 1'b1;
            spm_y_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CLR;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CLR: begin
          spm_clr_q <= 1'b0;
          cnt_q     <= '0;
          spm_y_q   <= spm_y_d;
          state_q   <= RUN;
        end
        RUN: begin
          cnt_q   <= idx_d;
          spm_y_q <= spm_y_d;
          if (cnt_q >= CW'(P_LAT)) out_p_q <= {spm_p, out_p_q[2*WIDTH-1:1]};
          if (cnt_q == CW'(RUNLEN-1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign spm_x     = spm_x_q;
  assign spm_y     = spm_y_q;
  assign spm_clr   = spm_clr_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_spm_host_if.sv
// Bench for spm_host_if: behavioural spm model plus arithmetic reference product, randomized operands.
module tb_spm_host_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_x, in_y, spm_x;
  logic        spm_y, spm_clr, spm_p;
  logic        out_valid, out_ready;
  logic [15:0] out_p;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spm_host_if #(.WIDTH(8), .P_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .spm_x(spm_x), .spm_y(spm_y), .spm_clr(spm_clr), .spm_p(spm_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  // spm stand-in: accumulates serial y bits and emits product bit k one cycle after y bit k.
  int          k;
  logic [15:0] yacc, xext, prod;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; yacc = '0; spm_p <= 1'b0;
    end else if (spm_clr) begin
      k = 0; yacc = '0; spm_p <= 1'b0;
    end else if (k < 16) begin
`ifdef SPM_HOST_SIGNED_EN
      xext = {{8{spm_x[7]}}, spm_x};
`else
      xext = {8'h00, spm_x};
`endif
      yacc[k] = spm_y;
      prod = xext * yacc;
      spm_p <= prod[k];
      k++;
    end else begin
      spm_p <= 1'b0;
    end
  end

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] sp;
    logic [15:0] up;
`ifdef SPM_HOST_SIGNED_EN
    sp = $signed(x) * $signed(y);
    return sp;
`else
    up = {8'h00, x} * {8'h00, y};
    return up;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int stall, input bit b2b);
    int waited, lat, clrs;
    logic [15:0] exp, held;
    exp = ref_prod(x, y);
    in_x = x; in_y = y; in_valid = 1'b1; out_ready = 1'b0;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk); waited++;
    end
    if (waited >= 50) check("accept_timeout", 0, 1);
    if (b2b) check("b2b_accept_wait", waited, 0);
    @(posedge clk); #1;
    if (!b2b) in_valid = 1'b0;
    lat = 0; clrs = 0;
    @(negedge clk);
    if (spm_clr) clrs++;
    check("spm_x_load", spm_x, x);
    while (!out_valid && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (spm_clr) clrs++;
    end
    check("latency", lat, 18);
    check("clr_pulses", clrs, 1);
    check("out_p", out_p, exp);
    if (stall > 0) begin
      held = out_p;
      in_valid = 1'b1; in_x = ~x; in_y = ~y;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", out_valid, 1);
        check("stall_out_p", out_p, held);
        check("stall_in_ready", in_ready, 0);
        check("stall_spm_x", spm_x, x);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_spm_x", spm_x, 0);
    check("rst_spm_y", spm_y, 0);
    check("rst_spm_clr", spm_clr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    do_op(8'd3, 8'd5, 0, 1'b0);
`ifdef SPM_HOST_SIGNED_EN
    do_op(8'hFF, 8'h02, 0, 1'b0);
    do_op(8'h80, 8'h80, 0, 1'b0);
`else
    do_op(8'hFF, 8'hFF, 0, 1'b0);
`endif
    do_op(8'hA5, 8'h3C, 10, 1'b0);
    repeat (20) do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);

    // reset during RUN at cnt=5
    in_x = 8'h5A; in_y = 8'hC3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_spm_x_loaded", spm_x, 8'h5A);
    rst = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 0);
    check("mid_spm_x", spm_x, 0);
    check("mid_spm_y", spm_y, 0);
    check("mid_spm_clr", spm_clr, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_p", out_p, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    do_op(8'd2, 8'd7, 0, 1'b0);

    do_op(8'd11, 8'd13, 0, 1'b0);
    do_op(8'($urandom), 8'($urandom), 0, 1'b1);
    do_op(8'($urandom), 8'($urandom), 0, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
